// File: rtl/msdap_output_serializer_pkg.sv
// Shared definitions for the MSDAP output serializer: FSM states and the
// default result word width coming out of the filter ALU accumulator.
package msdap_output_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int MSDAP_RESULT_W = 40;
    localparam int MSDAP_CNT_W    = 6;

endpackage

// File: rtl/msdap_output_serializer_piso_channel.sv
// One output channel: a one-deep holding register fed by the ALU, a full
// flag, a sticky overrun flag and the parallel-in/serial-out shift register
// that feeds the serial pin MSB-first.
module msdap_piso_channel
    import msdap_output_serializer_pkg::*;
#(
    parameter int DATA_W = MSDAP_RESULT_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic              shift_en,
    output logic              full,
    output logic              overrun,
    output logic              msb
);

    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] shift_reg;

    // Capture a new result; a fresh capture keeps the buffer full even when the old word leaves this cycle
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hold <= '0;
            full <= 1'b0;
        end else if (valid) begin
            hold <= data;
            full <= 1'b1;
        end else if (load) begin
            full <= 1'b0;
        end
    end

    // Flag a word lost because it was overwritten before reaching the shift register
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            overrun <= 1'b0;
        end else if (valid && full && !load) begin
            overrun <= 1'b1;
        end
    end

    // Load the old held word on transfer, then shift left with zero fill so the register drains to zero
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= hold;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        end
    end

    assign msb = shift_reg[DATA_W-1];

endmodule

// File: rtl/msdap_output_serializer.sv
// Last MSDAP datapath stage: buffers the left/right ALU results and, on a
// frame sync with both words present, shifts them out MSB-first on sol/sor.
// CNT_W must be wide enough to count DATA_W bits (2**CNT_W >= DATA_W).
module msdap_output_serializer
    import msdap_output_serializer_pkg::*;
#(
    parameter int DATA_W = MSDAP_RESULT_W,
    parameter int CNT_W  = MSDAP_CNT_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              left_valid,
    input  logic [DATA_W-1:0] left_data,
    input  logic              right_valid,
    input  logic [DATA_W-1:0] right_data,
    input  logic              frame,
    output logic              sol,
    output logic              sor,
    output logic              out_ready,
    output logic              overrun,
    output logic              underrun
);

    ser_state_e       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             full_l;
    logic             full_r;
    logic             ovr_l;
    logic             ovr_r;
    logic             msb_l;
    logic             msb_r;
    logic             load;
    logic             shift_en;

    assign load     = (state == IDLE) && frame && full_l && full_r;
    assign shift_en = (state == SHIFT);

    msdap_piso_channel #(.DATA_W(DATA_W)) u_left (
        .clk      (clk),
        .clear_n  (clear_n),
        .valid    (left_valid),
        .data     (left_data),
        .load     (load),
        .shift_en (shift_en),
        .full     (full_l),
        .overrun  (ovr_l),
        .msb      (msb_l)
    );

    msdap_piso_channel #(.DATA_W(DATA_W)) u_right (
        .clk      (clk),
        .clear_n  (clear_n),
        .valid    (right_valid),
        .data     (right_data),
        .load     (load),
        .shift_en (shift_en),
        .full     (full_r),
        .overrun  (ovr_r),
        .msb      (msb_r)
    );

    // Frame FSM: start on a frame with both words buffered, count DATA_W bits, ignore frames while shifting
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            underrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame) begin
                        if (full_l && full_r) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Serial pins and flags come straight from registers, gated to zero outside a frame
    assign out_ready = (state == SHIFT);
    assign sol       = out_ready & msb_l;
    assign sor       = out_ready & msb_r;
    assign overrun   = ovr_l | ovr_r;

endmodule

// File: tb/tb_msdap_output_serializer.sv
// Bench for msdap_output_serializer: directed scenarios followed by random
// traffic, every output compared each cycle against a word-level model.
module tb_msdap_output_serializer;
    import msdap_output_serializer_pkg::*;

    localparam int DATA_W = MSDAP_RESULT_W;
    localparam int CNT_W  = MSDAP_CNT_W;

    logic              clk = 1'b0;
    logic              clear_n = 1'b0;
    logic              left_valid = 1'b0;
    logic              right_valid = 1'b0;
    logic              frame = 1'b0;
    logic [DATA_W-1:0] left_data = '0;
    logic [DATA_W-1:0] right_data = '0;
    logic              sol;
    logic              sor;
    logic              out_ready;
    logic              overrun;
    logic              underrun;

    int compare_count = 0;
    int fail_count = 0;

    // Reference model: buffered words, words in flight and bits still to send
    logic [DATA_W-1:0] m_hold_l, m_hold_r, m_send_l, m_send_r;
    bit                m_full_l, m_full_r, m_overrun, m_underrun;
    int                m_remaining;

    msdap_output_serializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .left_valid  (left_valid),
        .left_data   (left_data),
        .right_valid (right_valid),
        .right_data  (right_data),
        .frame       (frame),
        .sol         (sol),
        .sor         (sor),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .underrun    (underrun)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic model_reset();
        m_hold_l = '0; m_hold_r = '0; m_send_l = '0; m_send_r = '0;
        m_full_l = 0; m_full_r = 0; m_overrun = 0; m_underrun = 0;
        m_remaining = 0;
    endtask

    task automatic model_edge();
        bit moved;
        moved = 0;
        if (m_remaining > 0) begin
            m_remaining--;
        end else if (frame) begin
            if (m_full_l && m_full_r) begin
                m_send_l = m_hold_l;
                m_send_r = m_hold_r;
                m_remaining = DATA_W;
                m_full_l = 0;
                m_full_r = 0;
                moved = 1;
            end else begin
                m_underrun = 1;
            end
        end
        if (left_valid) begin
            if (m_full_l && !moved) m_overrun = 1;
            m_hold_l = left_data;
            m_full_l = 1;
        end
        if (right_valid) begin
            if (m_full_r && !moved) m_overrun = 1;
            m_hold_r = right_data;
            m_full_r = 1;
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkOutput();
        logic exp_l, exp_r;
        exp_l = (m_remaining > 0) ? m_send_l[m_remaining-1] : 1'b0;
        exp_r = (m_remaining > 0) ? m_send_r[m_remaining-1] : 1'b0;
        check_bit("sol", sol, exp_l);
        check_bit("sor", sor, exp_r);
        check_bit("out_ready", out_ready, m_remaining > 0);
        check_bit("overrun", overrun, m_overrun);
        check_bit("underrun", underrun, m_underrun);
    endtask

    task automatic applyStimulus(input logic lv, input logic [DATA_W-1:0] ld,
                                 input logic rv, input logic [DATA_W-1:0] rd,
                                 input logic fr);
        @(negedge clk);
        left_valid = lv; left_data = ld;
        right_valid = rv; right_data = rd;
        frame = fr;
        @(posedge clk);
        if (clear_n) model_edge();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        return DATA_W'({$urandom(), $urandom()});
    endfunction

    // Directed scenarios, then random traffic, then the summary
    initial begin
        logic [DATA_W-1:0] w_a, w_b, w_one;
        w_a   = {(DATA_W/2){2'b10}};
        w_b   = {(DATA_W/2){2'b01}};
        w_one = DATA_W'(1);

        $display("[TB] reset");
        model_reset();
        clear_n = 1'b0;
        #12;
        checkOutput();
        @(negedge clk);
        clear_n = 1'b1;
        idle(2);

        $display("[TB] basic frame");
        applyStimulus(1'b1, 40'h80_0000_0001, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 40'h00_0000_0003, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(42);

        $display("[TB] underrun with left only, then complete frame");
        applyStimulus(1'b1, 40'h12_3456_789A, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);
        applyStimulus(1'b0, '0, 1'b1, 40'hFE_DCBA_9876, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(42);

        $display("[TB] overrun on left");
        applyStimulus(1'b1, w_a, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, w_b, 1'b1, rand_word(), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(42);

        $display("[TB] valid and transfer in the same cycle");
        model_reset();
        clear_n = 1'b0;
        #1;
        checkOutput();
        @(negedge clk);
        clear_n = 1'b1;
        applyStimulus(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        applyStimulus(1'b1, w_one, 1'b1, w_one, 1'b1);
        idle(41);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(42);

        $display("[TB] frame during shift is ignored");
        applyStimulus(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(19);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(25);

        $display("[TB] back-to-back frames at minimum period");
        applyStimulus(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        idle(38);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(42);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(30);
        #2;
        clear_n = 1'b0;
        model_reset();
        #1;
        checkOutput();
        @(negedge clk);
        clear_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);

        $display("[TB] random traffic");
        model_reset();
        clear_n = 1'b0;
        #1;
        checkOutput();
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 29) == 0), rand_word(),
                          ($urandom_range(0, 29) == 0), rand_word(),
                          ($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/msdap_output_serializer.md
Name: msdap_output_serializer

Overview:
Downstream stage of the filter ALU. Captures each channel's 40-bit result_reg when output_en pulses, buffers it in a one-deep holding register, and shifts left/right results out MSB-first on SOL/SOR when a frame sync arrives. It is the last stage of the MSDAP datapath before the chip's serial output pins.

Parameters:
DATA_W, 40, width of one channel result word (matches ALU accumulator).
CNT_W, 6, width of bit counter; must satisfy 2**CNT_W >= DATA_W.

Ports:
clk  input  1  system clock (SCLK domain, same as ALU).
clear_n  input  1  asynchronous, active-low reset.
left_valid  input  1  one-cycle pulse; left ALU output_en.
left_data  input  DATA_W  left ALU result_reg; sampled when left_valid=1.
right_valid  input  1  one-cycle pulse; right ALU output_en.
right_data  input  DATA_W  right ALU result_reg; sampled when right_valid=1.
frame  input  1  one-cycle frame-sync pulse requesting start of an output frame.
sol  output  1  left serial output, MSB first.
sor  output  1  right serial output, MSB first.
out_ready  output  1  high while sol/sor carry valid bits.
overrun  output  1  sticky; a result was overwritten before being sent.
underrun  output  1  sticky; frame arrived without both results buffered.

Behaviour:
- Reset (clear_n=0, async): state=IDLE, hold_l/hold_r=0, full_l/full_r=0, shift regs=0, bit_cnt=0; sol=sor=out_ready=overrun=underrun=0. Reset mid-frame aborts the frame immediately; partial word is lost.
- Capture: left_valid=1 -> hold_l<=left_data, full_l<=1 (same for right, independently). Channels may arrive in any order or in the same cycle.
- Overrun: valid while full and that hold is not transferred in the same cycle -> new data overwrites hold, overrun<=1 (sticky until reset).
- States: IDLE, SHIFT.
- IDLE: frame=1 and full_l=full_r=1 -> shift_l<=hold_l, shift_r<=hold_r, full_l/full_r<=0, bit_cnt<=0, go SHIFT. frame=1 with either hold empty -> stay IDLE, underrun<=1, holds untouched.
- SHIFT: each cycle shift_l/shift_r shift left by 1 (zero fill), bit_cnt+1. When bit_cnt=DATA_W-1 -> IDLE next cycle.
- Output: sol=shift_l[DATA_W-1], sor=shift_r[DATA_W-1], out_ready=1 in SHIFT; all forced 0 in IDLE. All three driven from registers (no combinational path from inputs).
- Latency: frame sampled at edge N -> bit DATA_W-1 visible after edge N; bit 0 visible after edge N+DATA_W-1; out_ready high exactly DATA_W cycles.
- frame during SHIFT: ignored (no underrun, no restart).
- Simultaneous valid and transfer (frame in IDLE, same cycle): transfer takes old hold value; hold captures new data, full stays 1; no overrun.
- Back-to-back frames: next frame accepted on first IDLE cycle after a SHIFT, giving a minimum frame period of DATA_W+1 cycles.

Decomposition:
- Shared msdap package: state enum ser_state_e {IDLE, SHIFT}; constant MSDAP_RESULT_W=40 (default for DATA_W).
- One natural sub-module: msdap_piso_channel (hold register, full flag, overrun, shift register), instantiated twice. Top holds FSM, bit counter, and underrun logic.

Test Plan:
- Reset, then left_valid with left_data=40'h80_0000_0001 and right_valid with right_data=40'h00_0000_0003, then frame -> out_ready high 40 cycles; sol=1, 38 zeros, 1; sor=38 zeros, 1, 1.
- frame with only left loaded -> underrun=1, out_ready stays 0, hold_l preserved; later right_valid plus frame -> normal 40-bit frame.
- Two left_valid (40'hAA.., then 40'h55..) before frame -> overrun=1; sol emits the 40'h55.. pattern.
- frame and left_valid/right_valid (new data 40'h1) in same IDLE cycle -> old words shifted out, no overrun; the next frame emits 40'h1 on both channels.
- Assert frame again at cycle 20 of SHIFT -> ignored; frame still 40 bits, underrun=0.
- Pull clear_n low at bit 10 of a frame -> sol/sor/out_ready=0 immediately; flags and holds cleared; next frame with no data -> underrun=1.
